// File: rtl/segment_readback.sv
// Two-digit 7-segment readback: rebuilds the displayed count and flags illegal codes and countdown breaks.
// Latency: outputs update STABLE_CYCLES edges after the first edge that samples a new pattern.
// Backpressure: none; the input is sampled every cycle and glitches shorter than the window are ignored.
module segment_readback #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_a,
    input  logic [6:0] seg_b,
    output logic [6:0] value,
    output logic       value_valid,
    output logic       value_update,
    output logic       decode_err,
    output logic       step_err
);

    typedef enum logic [1:0] {IDLE, SETTLE, VALID, ERR} state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Returns {legal, digit}; bit order is {a,b,c,d,e,f,g}.
    function automatic logic [4:0] dec7(input logic [6:0] s);
        case (s)
            7'b1111110: dec7 = 5'b1_0000;
            7'b0110000: dec7 = 5'b1_0001;
            7'b1101101: dec7 = 5'b1_0010;
            7'b1111001: dec7 = 5'b1_0011;
            7'b0110011: dec7 = 5'b1_0100;
            7'b1011011: dec7 = 5'b1_0101;
            7'b1011111: dec7 = 5'b1_0110;
            7'b1110000: dec7 = 5'b1_0111;
            7'b1111111: dec7 = 5'b1_1000;
            7'b1111011: dec7 = 5'b1_1001;
            default:    dec7 = 5'b0_0000;
        endcase
    endfunction

    state_t           state, state_nxt;
    logic [6:0]       samp_a, samp_b;
    logic [CNT_W-1:0] stab_cnt;
    logic             diff, stable, legal, accept, reject;
    logic             change, step_bad;
    logic [4:0]       dec_a, dec_b;
    logic [6:0]       new_val;

    assign diff    = (seg_a != samp_a) || (seg_b != samp_b);
    assign stable  = stab_cnt >= STABLE_LAST;
    assign dec_a   = dec7(samp_a);
    assign dec_b   = dec7(samp_b);
    assign legal   = dec_a[4] & dec_b[4];
    assign new_val = {3'b000, dec_a[3:0]} * 7'd10 + {3'b000, dec_b[3:0]};

    // A held value of 0 permits any reload; otherwise only a decrement by one is legal.
    assign change   = (new_val != value) || !value_valid;
    assign step_bad = value_valid && (new_val != value) && (value != 7'd0)
                      && (new_val != value - 7'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a   <= '0;
            samp_b   <= '0;
            stab_cnt <= '0;
        end else begin
            samp_a <= seg_a;
            samp_b <= seg_b;
            if (diff)
                stab_cnt <= '0;
            else if (stab_cnt != {CNT_W{1'b1}})
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            IDLE:   state_nxt = SETTLE;
            SETTLE: begin
                if (stable) begin
                    accept    = legal;
                    reject    = !legal;
                    state_nxt = legal ? VALID : ERR;
                    // A new pattern landing on the decision edge starts its own settle window.
                    if (diff)
                        state_nxt = SETTLE;
                end
            end
            VALID, ERR: begin
                if (diff)
                    state_nxt = SETTLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value        <= '0;
            value_valid  <= 1'b0;
            value_update <= 1'b0;
            decode_err   <= 1'b0;
            step_err     <= 1'b0;
        end else begin
            value_update <= 1'b0;
            step_err     <= 1'b0;
            if (accept) begin
                value        <= new_val;
                value_valid  <= 1'b1;
                decode_err   <= 1'b0;
                value_update <= change;
                step_err     <= step_bad;
            end else if (reject) begin
                decode_err  <= 1'b1;
                value_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_segment_readback.sv
// Randomized bench for segment_readback against a run-length reference model of the display link.
module tb_segment_readback;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_a, seg_b;
    logic [6:0] value;
    logic       value_valid, value_update, decode_err, step_err;

    always #5 clk = ~clk;

    segment_readback #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .seg_a(seg_a), .seg_b(seg_b),
        .value(value), .value_valid(value_valid), .value_update(value_update),
        .decode_err(decode_err), .step_err(step_err)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] code [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    // Reference model: the pattern currently on the wire, how many edges it has been seen,
    // and the visible output state.
    logic [13:0] m_pat;
    int          m_run;
    int          m_val;
    bit          m_vv, m_upd, m_derr, m_step;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int digit_of(input logic [6:0] s);
        for (int i = 0; i < 10; i++)
            if (code[i] == s) return i;
        return -1;
    endfunction

    function automatic logic [13:0] pair(input int n);
        return {code[n / 10], code[n % 10]};
    endfunction

    task automatic model_reset();
        m_pat = '0; m_run = 1; m_val = 0;
        m_vv = 0; m_upd = 0; m_derr = 0; m_step = 0;
    endtask

    // One clock edge: a pattern seen on exactly S consecutive edges is judged on the next edge.
    task automatic model_edge(input logic [13:0] cur);
        int t, u, nv;
        m_upd = 0;
        m_step = 0;
        if (m_run == S) begin
            t = digit_of(m_pat[13:7]);
            u = digit_of(m_pat[6:0]);
            if (t >= 0 && u >= 0) begin
                nv = t * 10 + u;
                if (!m_vv || nv != m_val) begin
                    m_upd = 1;
                    if (m_vv && m_val != 0 && nv != m_val - 1) m_step = 1;
                end
                m_val = nv; m_vv = 1; m_derr = 0;
            end else begin
                m_derr = 1; m_vv = 0;
            end
        end
        if (cur == m_pat) begin
            if (m_run <= S) m_run++;
        end else begin
            m_pat = cur;
            m_run = 1;
        end
    endtask

    task automatic check_outputs();
        chk("value", int'(value), m_val);
        chk("value_valid", int'(value_valid), int'(m_vv));
        chk("value_update", int'(value_update), int'(m_upd));
        chk("decode_err", int'(decode_err), int'(m_derr));
        chk("step_err", int'(step_err), int'(m_step));
    endtask

    task automatic step(input logic [13:0] p);
        seg_a = p[13:7];
        seg_b = p[6:0];
        @(posedge clk);
        model_edge(p);
        #1 check_outputs();
    endtask

    task automatic hold(input logic [13:0] p, input int n);
        repeat (n) step(p);
    endtask

    // Asynchronous reset applied between edges; outputs must clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_value", int'(value), 0);
        chk("rst_valid", int'(value_valid), 0);
        chk("rst_update", int'(value_update), 0);
        chk("rst_decode_err", int'(decode_err), 0);
        chk("rst_step_err", int'(step_err), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [13:0] p;
        int          kind, n;
        rst_n = 1'b1;
        seg_a = '0;
        seg_b = '0;
        #2;
        do_reset();

        // "42" from reset: accepted on the fifth edge, no step check
        hold(pair(42), 5);
        chk("t1_value", int'(value), 42);
        chk("t1_update", int'(value_update), 1);
        chk("t1_step", int'(step_err), 0);

        hold(pair(41), 5);
        chk("t2_value41", int'(value), 41);
        chk("t2_step41", int'(step_err), 0);
        hold(pair(39), 5);
        chk("t2_value39", int'(value), 39);
        chk("t2_update39", int'(value_update), 1);
        chk("t2_step39", int'(step_err), 1);

        // short glitch to "38" then back to "39"
        hold(pair(38), 2);
        hold(pair(39), 6);
        chk("t3_value", int'(value), 39);
        chk("t3_valid", int'(value_valid), 1);

        hold({code[3], 7'b0000001}, 5);
        chk("t4_decode_err", int'(decode_err), 1);
        chk("t4_valid", int'(value_valid), 0);
        chk("t4_value_held", int'(value), 39);
        hold(pair(0), 5);
        chk("t4_value0", int'(value), 0);
        chk("t4_update0", int'(value_update), 1);
        chk("t4_derr_clear", int'(decode_err), 0);
        hold(pair(25), 5);
        chk("t4_value25", int'(value), 25);
        chk("t4_step25", int'(step_err), 0);

        // reset two cycles into a new pattern
        hold(pair(60), 2);
        do_reset();
        hold(pair(7), 5);
        chk("t5_value", int'(value), 7);
        chk("t5_step", int'(step_err), 0);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 19);
            n    = $urandom_range(1, 7);
            if (kind < 9)
                p = pair(m_val > 0 ? m_val - 1 : $urandom_range(0, 99));
            else if (kind < 14)
                p = pair($urandom_range(0, 99));
            else if (kind < 16)
                p = {code[$urandom_range(0, 9)], 7'($urandom)};
            else if (kind < 18)
                p = {7'($urandom), code[$urandom_range(0, 9)]};
            else if (kind == 18)
                p = {7'b0000000, 7'b0000000};
            else
                p = pair(m_val);
            hold(p, n);
            if ($urandom_range(0, 49) == 0)
                do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
